// File: rtl/wb_mul_pkg.sv
// wb_mul_pkg: register map, CTRL bit positions and FSM states shared by the multiplier files.
package wb_mul_pkg;
  localparam logic [31:0] OFF_OPA    = 32'h00;
  localparam logic [31:0] OFF_OPB    = 32'h04;
  localparam logic [31:0] OFF_CTRL   = 32'h08;
  localparam logic [31:0] OFF_RES_LO = 32'h0C;
  localparam logic [31:0] OFF_RES_HI = 32'h10;
  localparam int CTRL_START  = 0;
  localparam int CTRL_SIGNED = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_BUSY   = 8;
  localparam int CTRL_DONE   = 9;
  typedef enum logic {S_IDLE, S_RUN} state_t;
endpackage

// File: rtl/wb_seq_multiplier_core.sv
// wb_seq_multiplier_core: WIDTH-cycle shift-add multiplier on magnitudes, sign applied at the final write.
module wb_seq_multiplier_core
  import wb_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done_pulse,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, prod_q, prod_d, sum;
  logic [WIDTH-1:0] mplier_q, mplier_d, mag_a, mag_b;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, last;
  assign busy = state_q == S_RUN;
  assign done_pulse = last;
  assign product = prod_q;
  always_comb begin
    mag_a = signed_mode && a[WIDTH-1] ? -a : a;
    mag_b = signed_mode && b[WIDTH-1] ? -b : b;
    sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    last = state_q == S_RUN && cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    prod_d = prod_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_RUN;
        mcand_d = {{WIDTH{1'b0}}, mag_a};
        mplier_d = mag_b;
        acc_d = '0;
        cnt_d = '0;
        neg_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      end
    end else begin
      acc_d = sum;
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + 1'b1;
      state_d = last ? S_IDLE : S_RUN;
      prod_d = last ? (neg_q ? -sum : sum) : prod_q;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      prod_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      prod_q <= prod_d;
    end
endmodule

// File: rtl/wb_seq_multiplier.sv
// wb_seq_multiplier: pipelined Wishbone slave with operand/control/result registers around the multiplier core.
module wb_seq_multiplier
  import wb_mul_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          WIDTH        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  output logic        o_irq
);
  logic acc, wr, wr_ctrl, start, busy, done_pulse, done_q, done_d, sgn_q, irq_en_q, res_sgn_q, unused;
  logic sel_opa, sel_opb, sel_ctrl, sel_lo, sel_hi;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [2*WIDTH-1:0] product;
  logic [63:0] res_ext;
  logic [31:0] ctrl_rd, rdata;
  assign o_wb_stall = busy & i_wb_we;
  assign acc = i_wb_cyc & i_wb_stb & ~o_wb_stall;
  assign wr = acc & i_wb_we;
  assign sel_opa = i_wb_addr == BASE_ADDRESS + OFF_OPA;
  assign sel_opb = i_wb_addr == BASE_ADDRESS + OFF_OPB;
  assign sel_ctrl = i_wb_addr == BASE_ADDRESS + OFF_CTRL;
  assign sel_lo = i_wb_addr == BASE_ADDRESS + OFF_RES_LO;
  assign sel_hi = i_wb_addr == BASE_ADDRESS + OFF_RES_HI;
  assign wr_ctrl = wr & sel_ctrl;
  assign start = wr_ctrl & i_wb_data[CTRL_START];
  // A completing run beats a same-cycle clear; start clears done on its own edge.
  assign done_d = done_pulse | (done_q & ~start & ~(wr_ctrl & i_wb_data[CTRL_DONE]));
  assign res_ext = res_sgn_q ? 64'($signed(product)) : 64'(product);
  assign ctrl_rd = {22'd0, done_q, busy, 5'd0, irq_en_q, sgn_q, 1'b0};
  assign rdata = sel_opa ? 32'(opa_q) : sel_opb ? 32'(opb_q) : sel_ctrl ? ctrl_rd :
                 sel_lo ? res_ext[31:0] : sel_hi && WIDTH > 16 ? res_ext[63:32] : 32'd0;
  assign unused = ^{i_wb_data, res_ext};
  wb_seq_multiplier_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .reset(reset),
    .start(start),
    .signed_mode(i_wb_data[CTRL_SIGNED]),
    .a(opa_q),
    .b(opb_q),
    .busy(busy),
    .done_pulse(done_pulse),
    .product(product)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      opa_q <= '0;
      opb_q <= '0;
      sgn_q <= 1'b0;
      irq_en_q <= 1'b0;
      res_sgn_q <= 1'b0;
      done_q <= 1'b0;
      o_wb_ack <= 1'b0;
      o_wb_data <= '0;
      o_irq <= 1'b0;
    end else begin
      opa_q <= wr & sel_opa ? i_wb_data[WIDTH-1:0] : opa_q;
      opb_q <= wr & sel_opb ? i_wb_data[WIDTH-1:0] : opb_q;
      sgn_q <= wr_ctrl ? i_wb_data[CTRL_SIGNED] : sgn_q;
      irq_en_q <= wr_ctrl ? i_wb_data[CTRL_IRQ_EN] : irq_en_q;
      res_sgn_q <= done_pulse ? sgn_q : res_sgn_q;
      done_q <= done_d;
      o_wb_ack <= acc;
      o_wb_data <= acc ? rdata : o_wb_data;
      o_irq <= done_q & irq_en_q;
    end
endmodule

// File: doc/wb_seq_multiplier.md
# wb_seq_multiplier

Parametrised Wishbone-attached sequential shift-add multiplier, the successor to the fixed 4-bit ASMD multiplier slave. It adds a configurable operand width, an unsigned/signed mode, an explicit start/status register with sticky done and interrupt, and a deterministic latency of WIDTH cycles. It sits on the user-area Wishbone bus as a pipelined slave. Reads never stall, so firmware can poll status at any time.

## Interface
- BASE_ADDRESS, 32'h3000_0000, word address of register 0
- WIDTH, 8, operand width in bits (2..32); product is 2*WIDTH bits
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears every register
- i_wb_cyc  input  1  bus cycle active
- i_wb_stb  input  1  request strobe
- i_wb_we  input  1  write enable
- i_wb_addr  input  32  byte address
- i_wb_data  input  32  write data
- o_wb_ack  output  1  registered, one pulse per accepted request
- o_wb_stall  output  1  request not accepted this cycle
- o_wb_data  output  32  registered read data
- o_irq  output  1  registered, equal to done & irq_en

## Operation
- Register map (offset from BASE_ADDRESS):
  - +0x00 OPA: operand A, bits [WIDTH-1:0].
  - +0x04 OPB: operand B, bits [WIDTH-1:0].
  - +0x08 CTRL: bit0 start (write-1, reads 0), bit1 signed, bit2 irq_en, bit8 busy (RO), bit9 done (sticky; write 1 to clear).
  - +0x0C RES_LO: product bits [31:0].
  - +0x10 RES_HI: product bits [2*WIDTH-1:32]. Reads 0 when WIDTH ≤ 16.
- Accepted request: i_wb_cyc & i_wb_stb & !o_wb_stall.
  - Every accepted request is acked, including unmapped addresses.
  - Unmapped reads return 0. Unmapped writes are ignored.
- o_wb_stall = busy & i_wb_we. Writes are held off while running; reads always proceed.
- Start: accepted CTRL write with bit0=1 while idle.
  - Latches the signed bit, loads operands and clears done, all in the same edge.
- States:
  - IDLE: busy=0. Start goes to RUN, with counter=0.
  - RUN: busy=1. Each cycle, if the multiplier LSB is 1, the accumulator adds the multiplicand. The multiplicand shifts left 1 and the multiplier shifts right 1. The counter increments.
  - When counter reaches WIDTH-1, the final result is written, done is set, and the block returns to IDLE.
- There is no early exit. A zero operand still takes WIDTH cycles and yields 0.
- Unsigned mode: the operands are raw. RES_LO is zero-extended when 2*WIDTH < 32.
- Signed mode: the operands are two's complement.
  - At load, the magnitudes are taken into WIDTH-bit unsigned registers; -2^(WIDTH-1) is representable.
  - The result sign is A[W-1]^B[W-1]. The final write negates the sum when the sign is 1.
  - RES_LO/RES_HI are sign-extended to the full readback width.
- Result registers keep their value until the next final write; the start edge does not clear them.
- A CTRL write with start=1 and done-clear=1 together simply starts; done is already cleared by the start.
- A done-clear write while done is being set in the same cycle: the set wins.
- Reset mid-operation returns the block to IDLE and zeroes all registers, operands, results, ack, data and irq.

## Timing
- Reset values: o_wb_ack=0, o_wb_data=0, o_irq=0, o_wb_stall=0; all registers 0.
- Ack and read data appear one cycle after the accepting edge.
- Read data reflects register state at the accepting edge.
- Start accepted at edge E0:
  - busy=1 after E0.
  - done=1, busy=0 and result valid after edge E0+WIDTH.
  - o_irq rises after edge E0+WIDTH+1.
- Back-to-back accepted requests get back-to-back acks.
- A stalled write stays pending until busy drops, then it is accepted on the first cycle after edge E0+WIDTH.

## Structure
- Package wb_mul_pkg holds:
  - register offset constants;
  - CTRL bit indices;
  - the FSM state enum (S_IDLE, S_RUN).
- Sub-module wb_seq_multiplier_core contains the WIDTH-parametrised datapath and FSM. Its ports are start, signed_mode, a, b, busy, done_pulse and product.
- The top level holds the Wishbone decode, the register file, stall/ack logic, sticky done and irq.

## Test plan
- WIDTH=8, unsigned: OPA=200, OPB=150, start → busy for 8 cycles, then done=1, RES_LO=0x0000_7530, RES_HI=0.
- Signed mode: OPA=0xF9 (-7), OPB=13 → RES_LO=0xFFFF_FFA5. Also OPA=OPB=0x80 → RES_LO=0x0000_4000.
- Write OPA during RUN → o_wb_stall held, no ack, OPA unchanged. The write is accepted and acked the cycle after done rises.
- OPA=0, OPB=255, start → identical 8-cycle latency, RES_LO=0.
- Sticky done with irq_en=1 → o_irq high. CTRL write with bit9=1 → done and o_irq clear.
- Reset asserted mid-RUN → busy=0, all reads return 0, and no spurious ack.
- Read unmapped offset 0x20 → ack, data 0.
- WIDTH=32: 0xFFFF_FFFF × 0xFFFF_FFFF → RES_HI=0xFFFF_FFFE, RES_LO=0x0000_0001, after 32 cycles.
